shift_reg_universal: RTL and testbench

//  Parametrised universal shift register; successor to the fixed 8-bit PIPO register.

---
 rtl/shift_reg_universal.sv | 118 +++++++++++
 tb/tb_shift_reg_universal.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold/load/shift/rotate modes plus a counted serial burst with busy/done.
// Optional registered parity output q_parity when SHIFT_REG_UNIVERSAL_PARITY_EN is defined.
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
  ,
  output logic             q_parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] len_clamp;

  always_comb begin
    len_clamp = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // start wins over mode; q is left untouched on the request cycle
          if (len_clamp != '0) begin
            cnt_d   = len_clamp;
            dir_d   = dir;
            state_d = S_BURST;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          case (mode)
            3'b001:  q_d = d;
            3'b010:  q_d = {q_q[WIDTH-2:0], ser_in};
            3'b011:  q_d = {ser_in, q_q[WIDTH-1:1]};
            3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            default: q_d = q_q;
          endcase
        end
      end
      S_BURST: begin
        q_d   = dir_q ? {q_q[WIDTH-2:0], ser_in} : {ser_in, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign q_parity = parity_q;
`endif

  // During a burst the outgoing bit follows the latched direction, not the live dir input
  assign ser_out = ((state_q == S_BURST) ? dir_q : dir) ? q_q[WIDTH-1] : q_q[0];
  assign q       = q_q;
  assign busy    = (state_q == S_BURST);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal (WIDTH=8): directed scenarios plus randomized traffic.
module tb_shift_reg_universal;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          ser_in, start, dir;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  q;
  logic          ser_out, busy, done;
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
  logic          q_parity;
`endif

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .d        (d),
    .ser_in   (ser_in),
    .start    (start),
    .dir      (dir),
    .burst_len(burst_len),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
    ,
    .q_parity (q_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         so;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  logic [W-1:0] so_hist = '0;

  // reference model: word value, shifts still owed, direction, pending done pulse
  int unsigned m_q = 0;
  int          m_left = 0;
  bit          m_dir = 0;
  bit          m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned shift_word(int unsigned v, bit left, bit fill);
    if (left) return ((v * 2) % 256) + fill;
    return (v / 2) + (fill ? 128 : 0);
  endfunction

  // caller is at a negedge; drives one cycle of inputs and predicts the post-edge state
  task automatic step(input logic [2:0] md, input logic [W-1:0] dd, input logic si,
                      input logic st, input logic dr, input logic [CW-1:0] bl);
    exp_t e;
    int   n;
    mode = md; d = dd; ser_in = si; start = st; dir = dr; burst_len = bl;
    if (m_left > 0) begin
      m_q = shift_word(m_q, m_dir, si);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (st) begin
      n = (int'(bl) > W) ? W : int'(bl);
      if (n == 0) m_done = 1;
      else begin
        m_left = n;
        m_dir  = dr;
      end
    end else begin
      case (md)
        3'd1: m_q = int'(dd);
        3'd2: m_q = shift_word(m_q, 1'b1, si);
        3'd3: m_q = shift_word(m_q, 1'b0, si);
        3'd4: m_q = shift_word(m_q, 1'b1, m_q >= 128);
        3'd5: m_q = shift_word(m_q, 1'b0, m_q % 2 == 1);
        default: ;
      endcase
    end
    e.q    = W'(m_q);
    e.busy = (m_left > 0);
    e.done = m_done;
    e.so   = ((m_left > 0) ? m_dir : dr) ? (m_q >= 128) : (m_q % 2 == 1);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    start = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({tag, "_q"}, 32'(q), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
    chk({tag, "_par"}, 32'(q_parity), 32'h0);
`endif
    m_q = 0; m_left = 0; m_dir = 0; m_done = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // monitor: one expected entry per active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("ser_out", 32'(ser_out), 32'(e.so));
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
        chk("parity", 32'(q_parity), 32'(^e.q));
`endif
        if (busy) begin
          busy_cnt++;
          so_hist = {so_hist[W-2:0], ser_out};
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    reset_n = 1'b0; mode = '0; d = '0; ser_in = 1'b0; start = 1'b0; dir = 1'b0; burst_len = '0;
    @(negedge clk);
    do_reset("rst_init");

    // load then hold
    step(3'b001, 8'hA5, 0, 0, 0, 0);
    chk("load_A5", 32'(q), 32'hA5);
    repeat (3) step(3'b000, 8'h00, 1, 0, 0, 0);
    chk("hold_A5", 32'(q), 32'hA5);

    // reset in the middle of normal operation
    step(3'b100, 8'h00, 0, 0, 0, 0);
    do_reset("rst_mid");

    // rotate / shift sequence
    step(3'b001, 8'h81, 0, 0, 0, 0);
    step(3'b100, 8'h00, 0, 0, 0, 0);
    chk("rol_81", 32'(q), 32'h03);
    step(3'b101, 8'h00, 0, 0, 0, 0);
    step(3'b101, 8'h00, 0, 0, 0, 0);
    chk("ror2", 32'(q), 32'hC0);
    step(3'b010, 8'h00, 1, 0, 0, 0);
    chk("shl_1", 32'(q), 32'h81);

    // full-width right burst of B4 with zero fill
    step(3'b001, 8'hB4, 0, 0, 0, 0);
    busy_cnt = 0; done_cnt = 0; so_hist = '0;
    step(3'b001, 8'hFF, 0, 1, 0, 4'd8);
    repeat (9) step(3'b000, 8'h00, 0, 0, 0, 0);
    chk("b8_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("b8_done_pulses", 32'(done_cnt), 32'd1);
    chk("b8_ser_seq", 32'(so_hist), 32'h2D);
    chk("b8_q", 32'(q), 32'h00);

    // zero-length burst
    step(3'b001, 8'h3C, 0, 0, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    step(3'b001, 8'hFF, 1, 1, 0, 4'd0);
    step(3'b001, 8'hFF, 1, 1, 0, 4'd0);
    step(3'b000, 8'h00, 0, 0, 0, 0);
    chk("b0_busy", 32'(busy_cnt), 32'd0);
    chk("b0_done_pulses", 32'(done_cnt), 32'd1);
    chk("b0_q", 32'(q), 32'h3C);

    // left burst of 5 with noisy inputs
    step(3'b001, 8'h96, 0, 0, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    step(3'b000, 8'h00, 0, 1, 1, 4'd5);
    for (int i = 0; i < 6; i++)
      step(3'($urandom_range(7)), 8'($urandom), 1'($urandom), 1'(i % 2), 1'(~i % 2), 4'($urandom));
    chk("b5_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("b5_done_pulses", 32'(done_cnt), 32'd1);

    // abort a burst with reset after the third shift
    busy_cnt = 0; done_cnt = 0;
    step(3'b000, 8'h00, 1, 1, 1, 4'd5);
    repeat (3) step(3'b011, 8'h00, 1, 1, 0, 4'd2);
    do_reset("rst_burst");
    repeat (4) step(3'b000, 8'h00, 0, 0, 0, 0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(149) == 0) do_reset("rst_rand");
      else step(3'($urandom_range(7)), 8'($urandom), 1'($urandom), ($urandom_range(7) == 0),
                1'($urandom), 4'($urandom));
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
